// File: rtl/trap_ctrl_pkg.sv
// Shared types and constants for the machine-mode trap sequencer.
// Cause codes, FSM encoding, CSR bit indices and mstatus update helpers.
package trap_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_TRAP_SAVE    = 3'd1,
    ST_TRAP_JUMP    = 3'd2,
    ST_MRET_RESTORE = 3'd3,
    ST_MRET_JUMP    = 3'd4
  } trap_state_e;

  localparam logic [31:0] CAUSE_ILLEGAL = 32'd2;
  localparam logic [31:0] CAUSE_EBREAK  = 32'd3;
  localparam logic [31:0] CAUSE_ECALL   = 32'd11;
  localparam logic [31:0] CAUSE_IRQ_EXT = 32'h8000_000B;
  localparam logic [31:0] CAUSE_IRQ_TMR = 32'h8000_0007;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam int MIE_MTIE = 7;
  localparam int MIE_MEIE = 11;

  typedef struct packed {
    logic        we;
    logic        ctrl;
    logic [31:0] mstatus;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic [31:0] mie;
  } csr_wr_t;

  function automatic logic [31:0] mstatus_on_trap(
    input logic [31:0] s
  );
    logic [31:0] r;
    r = s;
    r[MSTATUS_MPIE] = s[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  function automatic logic [31:0] mstatus_on_mret(
    input logic [31:0] s
  );
    logic [31:0] r;
    r = s;
    r[MSTATUS_MIE]  = s[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    return r;
  endfunction

  function automatic logic [31:0] align4(
    input logic [31:0] a
  );
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/trap_ctrl_irq_sync.sv
// Two-flop synchronizer for one asynchronous interrupt line.
// Synchronous active-low reset clears both stages.
module irq_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_irq,
  output logic o_irq
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_irq;
      r_sync <= r_meta;
    end
  end

  assign o_irq = r_sync;

endmodule

// File: rtl/trap_ctrl.sv
// Trap/interrupt sequencer: save, then jump; mret restore, then jump.
// Define TRAP_VECTORED_EN to enable vectored interrupt targets.
module trap_ctrl
  import trap_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inst_valid_i,
  input  logic [31:0] inst_addr_i,
  input  logic        illegal_i,
  input  logic        ecall_i,
  input  logic        ebreak_i,
  input  logic        mret_i,
  input  logic        irq_ext_i,
  input  logic        irq_timer_i,
  input  logic [31:0] r_mstatus_i,
  input  logic [31:0] r_mepc_i,
  input  logic [31:0] r_mtvec_i,
  input  logic [31:0] r_mie_i,
  output logic        stall_o,
  output logic        flush_o,
  output logic        jump_o,
  output logic [31:0] jump_addr_o,
  output logic        csr_w_enable_o,
  output logic        csr_w_ctrl_enable_o,
  output logic [31:0] w_mstatus_o,
  output logic [31:0] w_mepc_o,
  output logic [31:0] w_mcause_o,
  output logic [31:0] w_mie_o,
  output logic        busy_o
);

  trap_state_e r_state;
  trap_state_e w_next;

  logic [31:0] r_cause;
  logic [31:0] r_addr;

  logic        w_ext_sync;
  logic        w_tmr_sync;
  logic        w_ext_pend;
  logic        w_tmr_pend;
  logic        w_is_trap;
  logic        w_is_mret;
  logic [31:0] w_cause;
  logic        w_idle;
  logic        w_acc_trap;
  logic        w_acc_mret;
  logic [31:0] w_trap_vec;
  csr_wr_t     w_wr;

  irq_sync u_sync_ext (
    .clk   (clk),
    .rst_n (rst_n),
    .i_irq (irq_ext_i),
    .o_irq (w_ext_sync)
  );

  irq_sync u_sync_tmr (
    .clk   (clk),
    .rst_n (rst_n),
    .i_irq (irq_timer_i),
    .o_irq (w_tmr_sync)
  );

  assign w_ext_pend = w_ext_sync
                    & r_mstatus_i[MSTATUS_MIE]
                    & r_mie_i[MIE_MEIE];
  assign w_tmr_pend = w_tmr_sync
                    & r_mstatus_i[MSTATUS_MIE]
                    & r_mie_i[MIE_MTIE];

  // Fixed priority; several sources may be active together.
  always_comb begin
    w_is_trap = 1'b0;
    w_is_mret = 1'b0;
    w_cause   = '0;
    if (illegal_i) begin
      w_is_trap = 1'b1;
      w_cause   = CAUSE_ILLEGAL;
    end else if (ebreak_i) begin
      w_is_trap = 1'b1;
      w_cause   = CAUSE_EBREAK;
    end else if (ecall_i) begin
      w_is_trap = 1'b1;
      w_cause   = CAUSE_ECALL;
    end else if (mret_i) begin
      w_is_mret = 1'b1;
    end else if (w_ext_pend) begin
      w_is_trap = 1'b1;
      w_cause   = CAUSE_IRQ_EXT;
    end else if (w_tmr_pend) begin
      w_is_trap = 1'b1;
      w_cause   = CAUSE_IRQ_TMR;
    end
  end

  assign w_idle     = (r_state == ST_IDLE);
  assign w_acc_trap = rst_n & w_idle & inst_valid_i & w_is_trap;
  assign w_acc_mret = rst_n & w_idle & inst_valid_i & w_is_mret;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_acc_trap) begin
          w_next = ST_TRAP_SAVE;
        end else if (w_acc_mret) begin
          w_next = ST_MRET_RESTORE;
        end
      end
      ST_TRAP_SAVE:    w_next = ST_TRAP_JUMP;
      ST_TRAP_JUMP:    w_next = ST_IDLE;
      ST_MRET_RESTORE: w_next = ST_MRET_JUMP;
      ST_MRET_JUMP:    w_next = ST_IDLE;
      default:         w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cause <= '0;
      r_addr  <= '0;
    end else if (w_acc_trap) begin
      r_cause <= w_cause;
      r_addr  <= inst_addr_i;
    end
  end

`ifdef TRAP_VECTORED_EN
  // Only interrupts are vectored; exceptions land on the base.
  always_comb begin
    w_trap_vec = align4(r_mtvec_i);
    if (r_mtvec_i[1:0] == 2'b01 && r_cause[31]) begin
      w_trap_vec = align4(r_mtvec_i)
                 + {r_cause[29:0], 2'b00};
    end
  end
`else
  logic w_unused_mode;
  assign w_unused_mode = ^r_mtvec_i[1:0];
  assign w_trap_vec    = align4(r_mtvec_i);
`endif

  always_comb begin
    w_wr        = '0;
    flush_o     = 1'b0;
    jump_o      = 1'b0;
    jump_addr_o = '0;
    unique case (r_state)
      ST_TRAP_SAVE: begin
        w_wr.we      = 1'b1;
        w_wr.ctrl    = 1'b1;
        w_wr.mepc    = r_addr;
        w_wr.mcause  = r_cause;
        w_wr.mstatus = mstatus_on_trap(r_mstatus_i);
        w_wr.mie     = r_mie_i;
      end
      ST_TRAP_JUMP: begin
        flush_o     = 1'b1;
        jump_o      = 1'b1;
        jump_addr_o = w_trap_vec;
      end
      ST_MRET_RESTORE: begin
        w_wr.we      = 1'b1;
        w_wr.ctrl    = 1'b1;
        w_wr.mepc    = r_mepc_i;
        w_wr.mstatus = mstatus_on_mret(r_mstatus_i);
        w_wr.mie     = r_mie_i;
      end
      ST_MRET_JUMP: begin
        flush_o     = 1'b1;
        jump_o      = 1'b1;
        jump_addr_o = align4(r_mepc_i);
      end
      default: ;
    endcase
  end

  assign csr_w_enable_o      = w_wr.we;
  assign csr_w_ctrl_enable_o = w_wr.ctrl;
  assign w_mstatus_o         = w_wr.mstatus;
  assign w_mepc_o            = w_wr.mepc;
  assign w_mcause_o          = w_wr.mcause;
  assign w_mie_o             = w_wr.mie;

  assign stall_o = ~w_idle | w_acc_trap | w_acc_mret;
  assign busy_o  = ~w_idle;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: exceptions, irqs, priority, mret, reset.
// Checks on the falling edge; inputs change on the falling edge too.
module tb_trap_ctrl;

  logic        clk;
  logic        rst_n;
  logic        inst_valid_i;
  logic [31:0] inst_addr_i;
  logic        illegal_i;
  logic        ecall_i;
  logic        ebreak_i;
  logic        mret_i;
  logic        irq_ext_i;
  logic        irq_timer_i;
  logic [31:0] r_mstatus_i;
  logic [31:0] r_mepc_i;
  logic [31:0] r_mtvec_i;
  logic [31:0] r_mie_i;
  logic        stall_o;
  logic        flush_o;
  logic        jump_o;
  logic [31:0] jump_addr_o;
  logic        csr_w_enable_o;
  logic        csr_w_ctrl_enable_o;
  logic [31:0] w_mstatus_o;
  logic [31:0] w_mepc_o;
  logic [31:0] w_mcause_o;
  logic [31:0] w_mie_o;
  logic        busy_o;

  int tests;
  int fails;

  trap_ctrl dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .inst_valid_i        (inst_valid_i),
    .inst_addr_i         (inst_addr_i),
    .illegal_i           (illegal_i),
    .ecall_i             (ecall_i),
    .ebreak_i            (ebreak_i),
    .mret_i              (mret_i),
    .irq_ext_i           (irq_ext_i),
    .irq_timer_i         (irq_timer_i),
    .r_mstatus_i         (r_mstatus_i),
    .r_mepc_i            (r_mepc_i),
    .r_mtvec_i           (r_mtvec_i),
    .r_mie_i             (r_mie_i),
    .stall_o             (stall_o),
    .flush_o             (flush_o),
    .jump_o              (jump_o),
    .jump_addr_o         (jump_addr_o),
    .csr_w_enable_o      (csr_w_enable_o),
    .csr_w_ctrl_enable_o (csr_w_ctrl_enable_o),
    .w_mstatus_o         (w_mstatus_o),
    .w_mepc_o            (w_mepc_o),
    .w_mcause_o          (w_mcause_o),
    .w_mie_o             (w_mie_o),
    .busy_o              (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_events();
    inst_valid_i = 1'b0;
    inst_addr_i  = '0;
    illegal_i    = 1'b0;
    ecall_i      = 1'b0;
    ebreak_i     = 1'b0;
    mret_i       = 1'b0;
    irq_ext_i    = 1'b0;
    irq_timer_i  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    clear_events();
    r_mstatus_i = '0;
    r_mepc_i    = '0;
    r_mtvec_i   = '0;
    r_mie_i     = '0;
    repeat (3) @(negedge clk);
    tests++;
    if ({stall_o, flush_o, jump_o, busy_o,
         csr_w_enable_o, csr_w_ctrl_enable_o} !== 6'b0) begin
      fails++;
      $display("FAIL reset_ctrl got %b want 000000",
        {stall_o, flush_o, jump_o, busy_o,
         csr_w_enable_o, csr_w_ctrl_enable_o});
    end
    tests++;
    if ({jump_addr_o, w_mstatus_o, w_mepc_o,
         w_mcause_o, w_mie_o} !== 160'b0) begin
      fails++;
      $display("FAIL reset_data got nonzero data outputs");
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ecall();
    r_mtvec_i    = 32'h100;
    r_mstatus_i  = 32'h8;
    r_mie_i      = 32'h0;
    inst_valid_i = 1'b1;
    inst_addr_i  = 32'h40;
    ecall_i      = 1'b1;
    #1;
    tests++;
    if ({stall_o, busy_o, csr_w_enable_o} !== 3'b100) begin
      fails++;
      $display("FAIL ecall_accept got %b want 100",
        {stall_o, busy_o, csr_w_enable_o});
    end
    @(negedge clk);
    tests++;
    if ({csr_w_enable_o, csr_w_ctrl_enable_o, stall_o,
         busy_o, jump_o} !== 5'b11110) begin
      fails++;
      $display("FAIL ecall_save_ctrl got %b want 11110",
        {csr_w_enable_o, csr_w_ctrl_enable_o, stall_o,
         busy_o, jump_o});
    end
    tests++;
    if (w_mepc_o !== 32'h40 || w_mcause_o !== 32'd11
        || w_mstatus_o !== 32'h1880 || w_mie_o !== 32'h0) begin
      fails++;
      $display("FAIL ecall_save got %h %h %h want 40 b 1880",
        w_mepc_o, w_mcause_o, w_mstatus_o);
    end
    clear_events();
    @(negedge clk);
    tests++;
    if ({jump_o, flush_o, stall_o, csr_w_enable_o} !== 4'b1110
        || jump_addr_o !== 32'h100) begin
      fails++;
      $display("FAIL ecall_jump got %b %h want 1110 100",
        {jump_o, flush_o, stall_o, csr_w_enable_o}, jump_addr_o);
    end
    @(negedge clk);
    tests++;
    if ({busy_o, stall_o, jump_o, flush_o} !== 4'b0) begin
      fails++;
      $display("FAIL ecall_idle got %b want 0000",
        {busy_o, stall_o, jump_o, flush_o});
    end
  endtask

  task automatic test_irq_ext();
    r_mtvec_i    = 32'h100;
    r_mstatus_i  = 32'h8;
    r_mie_i      = 32'h800;
    inst_valid_i = 1'b1;
    inst_addr_i  = 32'h200;
    irq_ext_i    = 1'b1;
    @(negedge clk);
    tests++;
    if (stall_o !== 1'b0) begin
      fails++;
      $display("FAIL irq_sync1 stall got %b want 0", stall_o);
    end
    @(negedge clk);
    tests++;
    if ({stall_o, busy_o} !== 2'b10) begin
      fails++;
      $display("FAIL irq_sync2 got %b want 10", {stall_o, busy_o});
    end
    @(negedge clk);
    tests++;
    if (csr_w_enable_o !== 1'b1 || w_mcause_o !== 32'h8000000B
        || w_mepc_o !== 32'h200 || w_mie_o !== 32'h800) begin
      fails++;
      $display("FAIL irq_ext_save got we=%b %h %h want 1 8000000b 200",
        csr_w_enable_o, w_mcause_o, w_mepc_o);
    end
    clear_events();
    repeat (2) @(negedge clk);
    tests++;
    if (busy_o !== 1'b0 || stall_o !== 1'b0) begin
      fails++;
      $display("FAIL irq_ext_done got %b want 00", {busy_o, stall_o});
    end
  endtask

  task automatic test_priority();
    r_mstatus_i = 32'h8;
    r_mie_i     = 32'h800;
    irq_ext_i   = 1'b1;
    repeat (2) @(negedge clk);
    inst_valid_i = 1'b1;
    inst_addr_i  = 32'h300;
    illegal_i    = 1'b1;
    ecall_i      = 1'b1;
    @(negedge clk);
    tests++;
    if (w_mcause_o !== 32'd2 || w_mepc_o !== 32'h300) begin
      fails++;
      $display("FAIL prio_cause got %h %h want 2 300",
        w_mcause_o, w_mepc_o);
    end
    illegal_i   = 1'b0;
    ecall_i     = 1'b0;
    inst_addr_i = 32'h304;
    @(negedge clk);
    tests++;
    if (jump_o !== 1'b1) begin
      fails++;
      $display("FAIL prio_jump got %b want 1", jump_o);
    end
    @(negedge clk);
    tests++;
    if ({busy_o, stall_o} !== 2'b01) begin
      fails++;
      $display("FAIL prio_reaccept got %b want 01", {busy_o, stall_o});
    end
    @(negedge clk);
    tests++;
    if (w_mcause_o !== 32'h8000000B || w_mepc_o !== 32'h304) begin
      fails++;
      $display("FAIL prio_irq got %h %h want 8000000b 304",
        w_mcause_o, w_mepc_o);
    end
    clear_events();
    repeat (2) @(negedge clk);
    tests++;
    if (busy_o !== 1'b0) begin
      fails++;
      $display("FAIL prio_done busy got %b want 0", busy_o);
    end
  endtask

  task automatic test_mret();
    r_mstatus_i  = 32'h80;
    r_mepc_i     = 32'h44;
    r_mie_i      = 32'h5;
    inst_valid_i = 1'b1;
    inst_addr_i  = 32'h80;
    mret_i       = 1'b1;
    #1;
    tests++;
    if (stall_o !== 1'b1) begin
      fails++;
      $display("FAIL mret_accept stall got %b want 1", stall_o);
    end
    @(negedge clk);
    tests++;
    if ({csr_w_enable_o, csr_w_ctrl_enable_o} !== 2'b11
        || w_mstatus_o !== 32'h88 || w_mepc_o !== 32'h44
        || w_mie_o !== 32'h5 || w_mcause_o !== 32'h0) begin
      fails++;
      $display("FAIL mret_restore got %b %h %h %h want 11 88 44 5",
        {csr_w_enable_o, csr_w_ctrl_enable_o},
        w_mstatus_o, w_mepc_o, w_mie_o);
    end
    clear_events();
    @(negedge clk);
    tests++;
    if ({jump_o, flush_o} !== 2'b11 || jump_addr_o !== 32'h44) begin
      fails++;
      $display("FAIL mret_jump got %b %h want 11 44",
        {jump_o, flush_o}, jump_addr_o);
    end
    @(negedge clk);
    tests++;
    if (busy_o !== 1'b0) begin
      fails++;
      $display("FAIL mret_idle busy got %b want 0", busy_o);
    end
  endtask

  task automatic test_vectored();
    logic [31:0] exp_addr;
`ifdef TRAP_VECTORED_EN
    exp_addr = 32'h11C;
`else
    exp_addr = 32'h100;
`endif
    r_mtvec_i    = 32'h101;
    r_mstatus_i  = 32'h8;
    r_mie_i      = 32'h80;
    inst_valid_i = 1'b1;
    inst_addr_i  = 32'h500;
    irq_timer_i  = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (w_mcause_o !== 32'h80000007 || w_mepc_o !== 32'h500) begin
      fails++;
      $display("FAIL tmr_save got %h %h want 80000007 500",
        w_mcause_o, w_mepc_o);
    end
    clear_events();
    @(negedge clk);
    tests++;
    if (jump_o !== 1'b1 || jump_addr_o !== exp_addr) begin
      fails++;
      $display("FAIL tmr_vector got %b %h want 1 %h",
        jump_o, jump_addr_o, exp_addr);
    end
    @(negedge clk);
    inst_valid_i = 1'b1;
    inst_addr_i  = 32'h600;
    ebreak_i     = 1'b1;
    @(negedge clk);
    tests++;
    if (w_mcause_o !== 32'd3) begin
      fails++;
      $display("FAIL ebreak_cause got %h want 3", w_mcause_o);
    end
    clear_events();
    @(negedge clk);
    tests++;
    if (jump_addr_o !== 32'h100) begin
      fails++;
      $display("FAIL exc_base got %h want 100", jump_addr_o);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    r_mtvec_i    = 32'h100;
    r_mstatus_i  = 32'h8;
    r_mie_i      = 32'h0;
    inst_valid_i = 1'b1;
    inst_addr_i  = 32'h40;
    ecall_i      = 1'b1;
    @(negedge clk);
    tests++;
    if (csr_w_enable_o !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_save we got %b want 1", csr_w_enable_o);
    end
    clear_events();
    rst_n = 1'b0;
    @(negedge clk);
    tests++;
    if ({stall_o, flush_o, jump_o, busy_o,
         csr_w_enable_o, csr_w_ctrl_enable_o} !== 6'b0
        || jump_addr_o !== 32'h0 || w_mcause_o !== 32'h0) begin
      fails++;
      $display("FAIL rstmid_abort got %b %h want 000000 0",
        {stall_o, flush_o, jump_o, busy_o,
         csr_w_enable_o, csr_w_ctrl_enable_o}, jump_addr_o);
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (jump_o !== 1'b0 || busy_o !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_after got %b want 00", {jump_o, busy_o});
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_ecall();
    test_irq_ext();
    test_priority();
    test_mret();
    test_vectored();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
